// File: rtl/uart_ext.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_ext -- UART with runtime baud divisor, selectable parity and stop bits,
// and FIFOs in both directions.
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   dvsr         oversample tick period minus one, in clk cycles
//   parity_mode  00 none, 01 even, 10 odd, 11 none (latched per frame)
//   stop2        1 = two stop bits, 0 = one (latched per frame)
//   rx           serial receive line, asynchronous to clk
//   rd_uart      pop one word from the RX FIFO
//   wr_uart      push w_data into the TX FIFO
//   w_data       TX write data
//   clr_err      clear the sticky error flags
//   tx           serial transmit line (idle high)
//   r_data       RX FIFO head, first-word-fall-through
//   rx_empty/rx_full/tx_empty/tx_full   FIFO status
//   parity_err/frame_err/overrun        sticky receive error flags
//   o_rx_state/o_tx_state               FSM state, for observation only
//
// Handshake: rd_uart/wr_uart are single-cycle strobes; a strobe is acted on
// at the rising edge where it is high, unless the FIFO rules below ignore it
// (read when empty, write when full without a simultaneous read).
// -----------------------------------------------------------------------------

// Synchronous FIFO with first-word-fall-through read data.
//   i_wr/i_wdata  write strobe and data
//   i_rd          read strobe (pops the head)
//   o_rdata       current head
//   o_empty/o_full status
module uart_ext_fifo #(
    parameter int FIFO_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr,
    input  logic [7:0] i_wdata,
    input  logic       i_rd,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full
);
    localparam int DEPTH = 1 << FIFO_W;
    localparam logic [FIFO_W:0] DEPTH_C = (FIFO_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [FIFO_W-1:0] r_wptr;
    logic [FIFO_W-1:0] r_rptr;
    logic [FIFO_W:0]   r_count;
    logic              w_do_wr;
    logic              w_do_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == DEPTH_C);

    // A write into a full FIFO is accepted only when a read frees the slot
    // in the same cycle; a read of an empty FIFO is ignored, so rd+wr while
    // empty degenerates to a plain write.
    assign w_do_wr = i_wr && (!o_full || i_rd);
    assign w_do_rd = i_rd && !o_empty;

    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module uart_ext #(
    parameter int FIFO_W = 2,
    parameter int DVSR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic              rx,
    input  logic              rd_uart,
    input  logic              wr_uart,
    input  logic [7:0]        w_data,
    input  logic              clr_err,
    output logic              tx,
    output logic [7:0]        r_data,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              tx_empty,
    output logic              tx_full,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic [2:0]        o_rx_state,
    output logic [2:0]        o_tx_state
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic f_par_en(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // Parity bit that makes the frame even (mode 01) or odd (mode 10).
    function automatic logic f_par_bit(input logic [7:0] d, input logic [1:0] mode);
        return (mode == 2'b10) ? ~(^d) : (^d);
    endfunction

    // ------------------------------------------------------------------
    // Oversample tick: one pulse every dvsr+1 clocks.
    // ------------------------------------------------------------------
    logic [DVSR_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == dvsr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt >= dvsr) begin
            // >= keeps the counter bounded if dvsr is lowered mid-count.
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // RX line synchroniser, idle-high after reset.
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM. Samples land mid-bit: 8 ticks into the start bit, then every
    // 16 ticks. Push and error events are registered one-cycle pulses.
    // ------------------------------------------------------------------
    state_t     r_rx_state;
    logic [3:0] r_rx_s;
    logic [2:0] r_rx_n;
    logic [7:0] r_rx_b;
    logic [1:0] r_rx_pmode;
    logic       r_rx_stop2;
    logic       r_rx_push;
    logic       r_rx_perr_evt;
    logic       r_rx_ferr_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state    <= ST_IDLE;
            r_rx_s        <= '0;
            r_rx_n        <= '0;
            r_rx_b        <= '0;
            r_rx_pmode    <= '0;
            r_rx_stop2    <= 1'b0;
            r_rx_push     <= 1'b0;
            r_rx_perr_evt <= 1'b0;
            r_rx_ferr_evt <= 1'b0;
        end else begin
            r_rx_push     <= 1'b0;
            r_rx_perr_evt <= 1'b0;
            r_rx_ferr_evt <= 1'b0;
            case (r_rx_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_rx_state <= ST_START;
                        r_rx_s     <= '0;
                        r_rx_pmode <= parity_mode;
                        r_rx_stop2 <= stop2;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'd7) begin
                            // Line back high at mid start bit: treat as a glitch.
                            r_rx_s     <= '0;
                            r_rx_n     <= '0;
                            r_rx_state <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_rx_s <= r_rx_s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'd15) begin
                            r_rx_s <= '0;
                            r_rx_b <= {r_rx_sync, r_rx_b[7:1]};
                            if (r_rx_n == 3'd7) begin
                                r_rx_n     <= '0;
                                r_rx_state <= f_par_en(r_rx_pmode) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_rx_n <= r_rx_n + 1'b1;
                            end
                        end else begin
                            r_rx_s <= r_rx_s + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'd15) begin
                            r_rx_s <= '0;
                            if (r_rx_sync != f_par_bit(r_rx_b, r_rx_pmode)) begin
                                r_rx_perr_evt <= 1'b1;
                            end
                            r_rx_state <= ST_STOP;
                        end else begin
                            r_rx_s <= r_rx_s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_rx_s == 4'd15) begin
                            r_rx_s <= '0;
                            if (!r_rx_sync) begin
                                r_rx_ferr_evt <= 1'b1;
                            end
                            if (r_rx_stop2 && (r_rx_n == 3'd0)) begin
                                r_rx_n <= 3'd1;
                            end else begin
                                // Errored words are still delivered.
                                r_rx_push  <= 1'b1;
                                r_rx_state <= ST_IDLE;
                            end
                        end else begin
                            r_rx_s <= r_rx_s + 1'b1;
                        end
                    end
                end
                default: r_rx_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rx_state = r_rx_state;

    // ------------------------------------------------------------------
    // RX FIFO and sticky flags. A push into a full FIFO is lost unless the
    // same cycle also pops, in which case both happen.
    // ------------------------------------------------------------------
    logic w_rx_drop;
    logic r_parity_err;
    logic r_frame_err;
    logic r_overrun;

    uart_ext_fifo #(.FIFO_W(FIFO_W)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (r_rx_push),
        .i_wdata (r_rx_b),
        .i_rd    (rd_uart),
        .o_rdata (r_data),
        .o_empty (rx_empty),
        .o_full  (rx_full)
    );

    assign w_rx_drop = r_rx_push && rx_full && !rd_uart;

    // Set events take priority over clr_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_rx_perr_evt)  r_parity_err <= 1'b1;
            else if (clr_err)   r_parity_err <= 1'b0;
            if (r_rx_ferr_evt)  r_frame_err  <= 1'b1;
            else if (clr_err)   r_frame_err  <= 1'b0;
            if (w_rx_drop)      r_overrun    <= 1'b1;
            else if (clr_err)   r_overrun    <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

    // ------------------------------------------------------------------
    // TX path. The FIFO is popped when leaving IDLE or at the very end of
    // STOP, so consecutive frames abut with no idle gap.
    // ------------------------------------------------------------------
    state_t     r_tx_state;
    logic [3:0] r_tx_s;
    logic [2:0] r_tx_n;
    logic [7:0] r_tx_b;
    logic       r_tx_pbit;
    logic       r_tx_pen;
    logic       r_tx_stop2;
    logic       r_tx;
    logic [7:0] w_tx_head;
    logic       w_tx_stop_done;
    logic       w_tx_pop;

    uart_ext_fifo #(.FIFO_W(FIFO_W)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_wr    (wr_uart),
        .i_wdata (w_data),
        .i_rd    (w_tx_pop),
        .o_rdata (w_tx_head),
        .o_empty (tx_empty),
        .o_full  (tx_full)
    );

    assign w_tx_stop_done = (r_tx_state == ST_STOP) && w_tick && (r_tx_s == 4'd15) &&
                            !(r_tx_stop2 && (r_tx_n == 3'd0));
    assign w_tx_pop = !tx_empty && ((r_tx_state == ST_IDLE) || w_tx_stop_done);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_s     <= '0;
            r_tx_n     <= '0;
            r_tx_b     <= '0;
            r_tx_pbit  <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx_stop2 <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_tx_s == 4'd15) begin
                            r_tx_s     <= '0;
                            r_tx_n     <= '0;
                            r_tx       <= r_tx_b[0];
                            r_tx_state <= ST_DATA;
                        end else begin
                            r_tx_s <= r_tx_s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_tx_s == 4'd15) begin
                            r_tx_s <= '0;
                            r_tx_b <= {1'b0, r_tx_b[7:1]};
                            if (r_tx_n == 3'd7) begin
                                r_tx_n <= '0;
                                if (r_tx_pen) begin
                                    r_tx       <= r_tx_pbit;
                                    r_tx_state <= ST_PARITY;
                                end else begin
                                    r_tx       <= 1'b1;
                                    r_tx_state <= ST_STOP;
                                end
                            end else begin
                                r_tx_n <= r_tx_n + 1'b1;
                                r_tx   <= r_tx_b[1];
                            end
                        end else begin
                            r_tx_s <= r_tx_s + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        if (r_tx_s == 4'd15) begin
                            r_tx_s     <= '0;
                            r_tx_n     <= '0;
                            r_tx       <= 1'b1;
                            r_tx_state <= ST_STOP;
                        end else begin
                            r_tx_s <= r_tx_s + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (r_tx_s == 4'd15) begin
                            r_tx_s <= '0;
                            if (r_tx_stop2 && (r_tx_n == 3'd0)) begin
                                r_tx_n <= 3'd1;
                            end else begin
                                r_tx_state <= ST_IDLE;
                            end
                        end else begin
                            r_tx_s <= r_tx_s + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx_state <= ST_IDLE;
                    r_tx       <= 1'b1;
                end
            endcase

            // Frame load overrides the transitions above (IDLE or STOP end).
            if (w_tx_pop) begin
                r_tx_state <= ST_START;
                r_tx_s     <= '0;
                r_tx_n     <= '0;
                r_tx_b     <= w_tx_head;
                r_tx_pbit  <= f_par_bit(w_tx_head, parity_mode);
                r_tx_pen   <= f_par_en(parity_mode);
                r_tx_stop2 <= stop2;
                r_tx       <= 1'b0;
            end
        end
    end

    assign tx         = r_tx;
    assign o_tx_state = r_tx_state;
endmodule

// File: tb/tb_uart_ext.sv
`timescale 1ns/1ps
module tb_uart_ext;
  logic        clk;
  logic        reset;
  logic [10:0] dvsr;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        rx_line;
  logic        rx_drv;
  logic        lb;
  logic        rd_uart;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        clr_err;
  logic        tx;
  logic [7:0]  r_data;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        parity_err, frame_err, overrun;
  logic [2:0]  rx_state, tx_state;

  int checks;
  int failures;
  logic       mon_en;
  logic [7:0] exp_q[$];

  assign rx_line = lb ? tx : rx_drv;

  uart_ext #(.FIFO_W(2), .DVSR_W(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .dvsr        (dvsr),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rx          (rx_line),
    .rd_uart     (rd_uart),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .clr_err     (clr_err),
    .tx          (tx),
    .r_data      (r_data),
    .rx_empty    (rx_empty),
    .rx_full     (rx_full),
    .tx_empty    (tx_empty),
    .tx_full     (tx_full),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .o_rx_state  (rx_state),
    .o_tx_state  (tx_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: pops the expected queue whenever the RX FIFO has data
  initial begin : monitor
    rd_uart = 1'b0;
    forever begin
      @(negedge clk);
      rd_uart = 1'b0;
      if (mon_en && reset && !rx_empty) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected actual=0x%0h required=none", r_data);
        end else begin
          check("rx_byte", {24'd0, r_data}, {24'd0, exp_q.pop_front()});
        end
        rd_uart = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = d;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // pbit < 0: no parity bit. bad_stop: stop bit low for the first 5/8 of it.
  task automatic send_frame(input logic [7:0] d, input int pbit, input bit bad_stop, input int bclk);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bclk) @(negedge clk);
    end
    if (pbit >= 0) begin
      rx_drv = pbit[0];
      repeat (bclk) @(negedge clk);
    end
    if (bad_stop) begin
      rx_drv = 1'b0;
      repeat (bclk * 5 / 8) @(negedge clk);
      rx_drv = 1'b1;
      repeat (bclk - bclk * 5 / 8) @(negedge clk);
    end else begin
      rx_drv = 1'b1;
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !rx_empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  logic [9:0] a5_bits;
  logic [7:0] burst [5];
  int         low_cnt;

  initial begin
    reset = 1'b1;
    dvsr = '0; parity_mode = 2'b00; stop2 = 1'b0;
    rx_drv = 1'b1; lb = 1'b0; wr_uart = 1'b0; w_data = '0; clr_err = 1'b0;
    mon_en = 1'b0; checks = 0; failures = 0;
    #1 reset = 1'b0;
    #2;
    // reset state, before any clock edge
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("rst_tx_empty", {31'd0, tx_empty}, 32'd1);
    check("rst_full", {30'd0, rx_full, tx_full}, 32'd0);
    check("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    check("rst_states", {26'd0, rx_state, tx_state}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 waveform at dvsr=0: start, LSB-first data, stop, 16 clk each
    a5_bits = 10'b1_10100101_0; // bit 0 = start, bits 8:1 = data, bit 9 = stop
    write_tx(8'hA5);
    @(posedge clk); #1;
    check("a5_tx_empty_after_pop", {31'd0, tx_empty}, 32'd1);
    for (int c = 0; c < 160; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if ((c % 16) == 0 || (c % 16) == 15)
        check($sformatf("a5_bit%0d_off%0d", c / 16, c % 16), {31'd0, tx}, {31'd0, a5_bits[c / 16]});
    end
    @(posedge clk); #1;
    check("a5_idle_after", {29'd0, tx_state}, 32'd0);
    check("a5_tx_high_after", {31'd0, tx}, 32'd1);

    // loopback, dvsr=3, even parity, two stop bits
    @(negedge clk);
    dvsr = 11'd3; parity_mode = 2'b01; stop2 = 1'b1; lb = 1'b1; mon_en = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
    write_tx(8'h00); write_tx(8'hFF); write_tx(8'h3C);
    wait_drain("lb_drain", 6000);
    check("lb_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);

    // parity error: even mode, frame carries odd parity
    @(negedge clk);
    lb = 1'b0; dvsr = 11'd0; parity_mode = 2'b01; stop2 = 1'b0;
    exp_q.push_back(8'h01);
    send_frame(8'h01, 0, 1'b0, 16);
    wait_drain("perr_drain", 200);
    check("perr_set", {31'd0, parity_err}, 32'd1);
    check("perr_no_ferr", {31'd0, frame_err}, 32'd0);
    pulse_clr();
    check("perr_cleared", {31'd0, parity_err}, 32'd0);
    // correct even parity, then correct odd parity
    exp_q.push_back(8'h03);
    send_frame(8'h03, 0, 1'b0, 16);
    wait_drain("even_ok_drain", 200);
    check("even_ok_no_perr", {31'd0, parity_err}, 32'd0);
    @(negedge clk);
    parity_mode = 2'b10;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 0, 1'b0, 16);
    wait_drain("odd_ok_drain", 200);
    check("odd_ok_no_perr", {31'd0, parity_err}, 32'd0);

    // framing error: stop sampled low, word still delivered
    @(negedge clk);
    parity_mode = 2'b00;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, -1, 1'b1, 16);
    wait_drain("ferr_drain", 200);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_no_perr", {31'd0, parity_err}, 32'd0);
    pulse_clr();
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // 4-clk low glitch is rejected
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_empty", {31'd0, rx_empty}, 32'd1);
    check("glitch_rx_idle", {29'd0, rx_state}, 32'd0);

    // overrun: five frames, no reads
    mon_en = 1'b0;
    send_frame(8'h11, -1, 1'b0, 16);
    send_frame(8'h22, -1, 1'b0, 16);
    send_frame(8'h33, -1, 1'b0, 16);
    send_frame(8'h44, -1, 1'b0, 16);
    repeat (4) @(negedge clk);
    check("ovr_full_at4", {31'd0, rx_full}, 32'd1);
    check("ovr_not_yet", {31'd0, overrun}, 32'd0);
    send_frame(8'h55, -1, 1'b0, 16);
    repeat (4) @(negedge clk);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_still_full", {31'd0, rx_full}, 32'd1);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    mon_en = 1'b1;
    wait_drain("ovr_drain", 100);
    pulse_clr();
    check("ovr_cleared", {31'd0, overrun}, 32'd0);

    // TX FIFO full: one frame in flight, four queued, fifth dropped
    burst[0] = 8'h12; burst[1] = 8'h34; burst[2] = 8'h56; burst[3] = 8'h78; burst[4] = 8'h9A;
    @(negedge clk);
    lb = 1'b1;
    exp_q.push_back(8'hC3);
    write_tx(8'hC3);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("txf_full_before5", {31'd0, tx_full}, 32'd1);
      wr_uart = 1'b1;
      w_data  = burst[i];
      @(negedge clk);
    end
    wr_uart = 1'b0;
    check("txf_full_after5", {31'd0, tx_full}, 32'd1);
    for (int i = 0; i < 4; i++) exp_q.push_back(burst[i]);
    wait_drain("txf_drain", 3000);
    repeat (200) @(negedge clk);
    check("txf_no_fifth", {31'd0, rx_empty}, 32'd1);
    check("txf_tx_empty", {31'd0, tx_empty}, 32'd1);

    // reset in the middle of a TX frame
    @(negedge clk);
    lb = 1'b0;
    write_tx(8'hF0);
    write_tx(8'h0F);
    repeat (30) @(negedge clk);
    check("mid_tx_low", {31'd0, tx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_tx_high", {31'd0, tx}, 32'd1);
    check("mid_rst_tx_empty", {31'd0, tx_empty}, 32'd1);
    check("mid_rst_tx_idle", {29'd0, tx_state}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!tx) low_cnt++;
    end
    check("post_rst_tx_silent", 32'(low_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
